// File: rtl/axis_mask_broadcaster_if.sv
// AXI4-Stream bundle for the mask broadcaster; N lanes flattened side by side.
// The master drives payload and valid, the slave drives ready.
interface axis_mask_broadcaster_if #(
   parameter int DW = 512,
   parameter int UW = 256,
   parameter int N  = 1
);
   logic [N*DW-1:0]     tdata;
   logic [N*(DW/8)-1:0] tkeep;
   logic [N*UW-1:0]     tuser;
   logic [N-1:0]        tvalid;
   logic [N-1:0]        tready;
   logic [N-1:0]        tlast;

   modport master (
      output tdata, tkeep, tuser, tvalid, tlast,
      input  tready
   );

   modport slave (
      input  tdata, tkeep, tuser, tvalid, tlast,
      output tready
   );
endinterface

// File: rtl/axis_mask_broadcaster.sv
// Replicates one AXI4-Stream input to M_INTF_NUM FIFO-backed outputs, routed by
// a per-packet destination mask; lossless back-pressure or per-output packet drop.
module axis_mask_broadcaster #(
   parameter int AXIS_DATA_WIDTH  = 512,
   parameter int AXIS_TUSER_WIDTH = 256,
   parameter int ADDR_WIDTH       = 6,
   parameter int M_INTF_NUM       = 4,
   parameter int MASK_LSB         = 0,
   parameter int DROP_ON_FULL     = 0
) (
   input  logic                  aclk,
   input  logic                  areset,
   axis_mask_broadcaster_if.slave  s_axis,
   axis_mask_broadcaster_if.master m_axis,
   output logic [M_INTF_NUM-1:0] drop_pulse
);
   localparam int  DW    = AXIS_DATA_WIDTH;
   localparam int  KW    = AXIS_DATA_WIDTH / 8;
   localparam int  UW    = AXIS_TUSER_WIDTH;
   localparam int  M     = M_INTF_NUM;
   localparam int  AW    = ADDR_WIDTH;
   localparam int  DEPTH = 1 << AW;
   localparam int  BW    = DW + KW + UW + 1;
   localparam bit  DROP  = (DROP_ON_FULL != 0);
   localparam logic [AW:0] ONE = {{AW{1'b0}}, 1'b1};

   typedef enum logic {
      IDLE,
      PKT
   } state_e;

   state_e state_q, state_d;
   logic [M-1:0] mask_q, mask_d;
   logic [M-1:0] cur_mask;
   logic         rdy_q, rdy_d;
   logic [M-1:0] flag_q, flag_d;
   logic [M-1:0] drop_q, drop_d;
   logic [AW:0]  wr_q [M];
   logic [AW:0]  wr_d [M];
   logic [AW:0]  cm_q [M];
   logic [AW:0]  cm_d [M];
   logic [AW:0]  rd_q [M];
   logic [AW:0]  rd_d [M];
   logic [M-1:0] full, empty, pop, we, nflag;
   logic [BW-1:0] mem_q [M][DEPTH];
   logic [BW-1:0] beat;
   logic          s_rdy, hs;

   assign beat = {s_axis.tdata, s_axis.tkeep,
                  s_axis.tuser, s_axis.tlast};

   // IDLE routes on the live sideband; inside a packet the latched mask wins
   assign cur_mask = (state_q == IDLE) ?
                     s_axis.tuser[MASK_LSB +: M] : mask_q;

   for (genvar g = 0; g < M; g++) begin : g_out
      assign full[g]  = (wr_q[g][AW] != rd_q[g][AW]) &&
                        (wr_q[g][AW-1:0] == rd_q[g][AW-1:0]);
      assign empty[g] = (cm_q[g] == rd_q[g]);
      assign pop[g]   = ~empty[g] & m_axis.tready[g];
      assign m_axis.tvalid[g] = ~empty[g];
      assign {m_axis.tdata[g*DW +: DW],
              m_axis.tkeep[g*KW +: KW],
              m_axis.tuser[g*UW +: UW],
              m_axis.tlast[g]} = mem_q[g][rd_q[g][AW-1:0]];
   end

   always_comb begin
      s_rdy = rdy_q;
      if (!DROP) s_rdy = rdy_q & ~|(cur_mask & full);
   end

   assign s_axis.tready = s_rdy;
   assign hs            = s_axis.tvalid & s_rdy;
   assign drop_pulse    = drop_q;

   always_comb begin
      state_d = state_q;
      mask_d  = mask_q;
      rdy_d   = 1'b1;
      flag_d  = flag_q;
      drop_d  = '0;
      we      = '0;
      nflag   = flag_q | full;
      for (int i = 0; i < M; i++) begin
         wr_d[i] = wr_q[i];
         cm_d[i] = cm_q[i];
         rd_d[i] = rd_q[i];
      end

      if (hs) begin
         if (s_axis.tlast) begin
            state_d = IDLE;
         end else if (state_q == IDLE) begin
            state_d = PKT;
            mask_d  = s_axis.tuser[MASK_LSB +: M];
         end
      end

      for (int i = 0; i < M; i++) begin
         if (pop[i]) rd_d[i] = rd_q[i] + ONE;
         if (hs && cur_mask[i]) begin
            if (!DROP) begin
               we[i]   = 1'b1;
               wr_d[i] = wr_q[i] + ONE;
               cm_d[i] = wr_q[i] + ONE;
            end else begin
               if (!nflag[i]) begin
                  we[i]   = 1'b1;
                  wr_d[i] = wr_q[i] + ONE;
               end
               // a flagged packet rolls back to the last committed boundary
               if (s_axis.tlast) begin
                  if (nflag[i]) begin
                     wr_d[i]   = cm_q[i];
                     flag_d[i] = 1'b0;
                     drop_d[i] = 1'b1;
                  end else begin
                     cm_d[i] = wr_q[i] + ONE;
                  end
               end else begin
                  flag_d[i] = nflag[i];
               end
            end
         end
      end
   end

   always_ff @(posedge aclk) begin
      if (areset) begin
         state_q <= IDLE;
         mask_q  <= '0;
         rdy_q   <= 1'b0;
         flag_q  <= '0;
         drop_q  <= '0;
         for (int i = 0; i < M; i++) begin
            wr_q[i] <= '0;
            cm_q[i] <= '0;
            rd_q[i] <= '0;
         end
      end else begin
         state_q <= state_d;
         mask_q  <= mask_d;
         rdy_q   <= rdy_d;
         flag_q  <= flag_d;
         drop_q  <= drop_d;
         for (int i = 0; i < M; i++) begin
            wr_q[i] <= wr_d[i];
            cm_q[i] <= cm_d[i];
            rd_q[i] <= rd_d[i];
         end
      end
   end

   always_ff @(posedge aclk) begin
      for (int i = 0; i < M; i++) begin
         if (we[i]) mem_q[i][wr_q[i][AW-1:0]] <= beat;
      end
   end
endmodule
